// File: rtl/sum_split_rx.sv
// sum_split_rx: recovers the outer operands of a pair-sum stream.
//
// A sender first transmits the shared middle operand in1 (ref_data), then later the
// two sums sum0 = in0 + in1 and sum1 = in1 + in2. References are queued in a small
// FIFO. Each sum beat pops one reference and yields out0 = in0 and out1 = in2.
//
// Parameters:
//   DATA_W : width of all data ports
//   DEPTH  : reference FIFO depth (power of two, 2..16)
//
// Ports:
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   ref_vld/ref_data  : reference (in1) push; ref_rdy is !full
//   sum_vld/sum0/sum1 : sum beat; pops the FIFO head when non-empty
//   out_vld/out0/out1 : registered recovered pair, one-cycle pulse per pop
//   err_ovf/err_unf   : sticky overflow / underflow flags
//
// Build option: define SUM_SPLIT_ERR_EN to implement the sticky error flags.
// Without it both flags are tied to 0 and no error flops exist.

module sum_split_rx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ref_vld,
    input  logic [DATA_W-1:0] ref_data,
    output logic              ref_rdy,
    input  logic              sum_vld,
    input  logic [DATA_W-1:0] sum0,
    input  logic [DATA_W-1:0] sum1,
    output logic              out_vld,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [DATA_W-1:0] head;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign ref_rdy = !full;
    // Full blocks pushes even with a same-cycle pop; empty blocks pops even with a
    // same-cycle push, so there is no push-through or bypass path.
    assign push    = ref_vld && !full;
    assign pop     = sum_vld && !empty;
    assign head    = mem[rd_ptr_q];

    // Storage is not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= ref_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Outputs update only on a pop and hold otherwise; differences wrap mod 2^DATA_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out0    <= '0;
            out1    <= '0;
        end else begin
            out_vld <= pop;
            if (pop) begin
                out0 <= sum0 - head;
                out1 <= sum1 - head;
            end
        end
    end

`ifdef SUM_SPLIT_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (ref_vld && full) begin
                err_ovf <= 1'b1;
            end
            if (sum_vld && empty) begin
                err_unf <= 1'b1;
            end
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_sum_split_rx.sv
// Scoreboard bench for sum_split_rx: directed stimulus pushes the hand-computed
// recovered pair into a queue; a monitor pops and compares on every out_vld.
module tb_sum_split_rx;

    localparam int unsigned DW = 8;

`ifdef SUM_SPLIT_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ref_vld = 1'b0;
    logic [DW-1:0] ref_data = '0;
    logic          ref_rdy;
    logic          sum_vld = 1'b0;
    logic [DW-1:0] sum0 = '0;
    logic [DW-1:0] sum1 = '0;
    logic          out_vld;
    logic [DW-1:0] out0;
    logic [DW-1:0] out1;
    logic          err_ovf;
    logic          err_unf;

    int errors = 0;
    int checks = 0;
    logic [2*DW-1:0] sb [$];

    sum_split_rx #(.DATA_W(DW), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ref_vld  (ref_vld),
        .ref_data (ref_data),
        .ref_rdy  (ref_rdy),
        .sum_vld  (sum_vld),
        .sum0     (sum0),
        .sum1     (sum1),
        .out_vld  (out_vld),
        .out0     (out0),
        .out1     (out1),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    always #5 clk = ~clk;

    // Monitor: every output pulse must match the oldest expected pair.
    always @(negedge clk) begin
        if (out_vld) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_pair: unexpected out_vld with out0=%h out1=%h, none required",
                         out0, out1);
            end else begin
                logic [2*DW-1:0] exp;
                exp = sb.pop_front();
                if ({out0, out1} !== exp) begin
                    errors++;
                    $display("FAIL out_pair: got out0=%h out1=%h, required out0=%h out1=%h",
                             out0, out1, exp[2*DW-1:DW], exp[DW-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [DW-1:0] o0, input logic [DW-1:0] o1);
        sb.push_back({o0, o1});
    endtask

    // Present one cycle of inputs, take the edge, then idle the strobes.
    task automatic step(input logic rv, input logic [DW-1:0] rd,
                        input logic sv, input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        ref_vld  = rv;
        ref_data = rd;
        sum_vld  = sv;
        sum0     = s0;
        sum1     = s1;
        @(posedge clk);
        #1;
        ref_vld = 1'b0;
        sum_vld = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ref_rdy", {7'd0, ref_rdy}, 8'd1);
        chk("rst_out_vld", {7'd0, out_vld}, 8'd0);
        chk("rst_out0", out0, 8'h00);
        chk("rst_out1", out1, 8'h00);
        chk("rst_err_ovf", {7'd0, err_ovf}, 8'd0);
        chk("rst_err_unf", {7'd0, err_unf}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic recovery, then outputs hold
        step(1'b1, 8'h10, 1'b0, 8'h00, 8'h00);
        expect_out(8'h05, 8'h20);
        step(1'b0, 8'h00, 1'b1, 8'h15, 8'h30);
        step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        chk("hold_out_vld", {7'd0, out_vld}, 8'd0);
        chk("hold_out0", out0, 8'h05);
        chk("hold_out1", out1, 8'h20);

        // Wrap-around arithmetic
        step(1'b1, 8'hF0, 1'b0, 8'h00, 8'h00);
        expect_out(8'h20, 8'hFF);
        step(1'b0, 8'h00, 1'b1, 8'h10, 8'hEF);

        // Simultaneous push and pop on a non-empty FIFO
        step(1'b1, 8'h01, 1'b0, 8'h00, 8'h00);
        expect_out(8'h02, 8'h03);
        step(1'b1, 8'h02, 1'b1, 8'h03, 8'h04);
        expect_out(8'h03, 8'h04);
        step(1'b0, 8'h00, 1'b1, 8'h05, 8'h06);
        chk("simul_ref_rdy", {7'd0, ref_rdy}, 8'd1);
        chk("no_err_ovf_yet", {7'd0, err_ovf}, 8'd0);
        chk("no_err_unf_yet", {7'd0, err_unf}, 8'd0);

        // Full FIFO: fill, overflow attempt, pop with a blocked same-cycle push
        step(1'b1, 8'h11, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h22, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h33, 1'b0, 8'h00, 8'h00);
        chk("three_ref_rdy", {7'd0, ref_rdy}, 8'd1);
        step(1'b1, 8'h44, 1'b0, 8'h00, 8'h00);
        chk("full_ref_rdy", {7'd0, ref_rdy}, 8'd0);
        step(1'b1, 8'h55, 1'b0, 8'h00, 8'h00);
        chk("ovf_err_ovf", {7'd0, err_ovf}, {7'd0, ERR_ON});
        chk("ovf_ref_rdy", {7'd0, ref_rdy}, 8'd0);
        expect_out(8'h01, 8'h02);
        step(1'b1, 8'h66, 1'b1, 8'h12, 8'h13);
        chk("pop1_ref_rdy", {7'd0, ref_rdy}, 8'd1);
        expect_out(8'h03, 8'h0E);
        step(1'b0, 8'h00, 1'b1, 8'h25, 8'h30);
        expect_out(8'h0D, 8'hCD);
        step(1'b0, 8'h00, 1'b1, 8'h40, 8'h00);
        expect_out(8'h00, 8'hFF);
        step(1'b0, 8'h00, 1'b1, 8'h44, 8'h43);

        // Underflow with a same-cycle push (0x55/0x66 must have been dropped)
        step(1'b1, 8'h70, 1'b1, 8'h80, 8'h81);
        chk("unf_out_vld", {7'd0, out_vld}, 8'd0);
        chk("unf_err_unf", {7'd0, err_unf}, {7'd0, ERR_ON});
        expect_out(8'h10, 8'h20);
        step(1'b0, 8'h00, 1'b1, 8'h80, 8'h90);
        chk("unf_consume_out_vld", {7'd0, out_vld}, 8'd1);

        // Mid-operation reset discards queued references
        step(1'b1, 8'h01, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h02, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h03, 1'b0, 8'h00, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_vld", {7'd0, out_vld}, 8'd0);
        chk("mrst_out0", out0, 8'h00);
        chk("mrst_out1", out1, 8'h00);
        chk("mrst_ref_rdy", {7'd0, ref_rdy}, 8'd1);
        chk("mrst_err_ovf", {7'd0, err_ovf}, 8'd0);
        chk("mrst_err_unf", {7'd0, err_unf}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b1, 8'h09, 8'h0A);
        chk("post_rst_out_vld", {7'd0, out_vld}, 8'd0);
        chk("post_rst_err_unf", {7'd0, err_unf}, {7'd0, ERR_ON});
        step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_split_rx.md
SUM_SPLIT_RX -- requirements
Module: sum_split_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the data width of all data ports.
REQ-002 SHALL have parameter DEPTH, default 4, giving the reference FIFO depth; legal values are powers of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all flops rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port ref_vld, input, 1 bit: ref_data valid.
REQ-006 SHALL have port ref_data, input, DATA_W bits: shared middle operand (in1) of a pair-sum stream, sent ahead of its sums.
REQ-007 SHALL have port ref_rdy, output, 1 bit: FIFO can accept ref_data; equals !full.
REQ-008 SHALL have port sum_vld, input, 1 bit: sum0/sum1 valid.
REQ-009 SHALL have port sum0, input, DATA_W bits: in0+in1 mod 2^DATA_W.
REQ-010 SHALL have port sum1, input, DATA_W bits: in1+in2 mod 2^DATA_W.
REQ-011 SHALL have port out_vld, output, 1 bit: out0/out1 valid, 1-cycle pulse per recovered pair.
REQ-012 SHALL have port out0, output, DATA_W bits: recovered in0.
REQ-013 SHALL have port out1, output, DATA_W bits: recovered in2.
REQ-014 SHALL have port err_ovf, output, 1 bit: sticky overflow flag.
REQ-015 SHALL have port err_unf, output, 1 bit: sticky underflow flag.

Function
REQ-016 SHALL push ref_data into a DEPTH-entry FIFO on a clock edge where ref_vld=1 and ref_rdy=1.
REQ-017 SHALL pop the FIFO head on a clock edge where sum_vld=1 and the FIFO is non-empty.
REQ-018 SHALL, on each pop, register out0=sum0-head and out1=sum1-head, both mod 2^DATA_W with carry/borrow discarded, and assert out_vld for exactly one cycle: a 1-cycle latency from sum_vld.
REQ-019 SHALL hold out0/out1 at their last values while out_vld=0.
REQ-020 SHALL keep a fill count from 0 to DEPTH, with full at DEPTH and empty at 0; pointers wrap modulo DEPTH.
REQ-021 SHALL, on simultaneous push and pop with the FIFO non-empty and not full, perform both and leave the count unchanged.
REQ-022 SHALL, when full, keep ref_rdy=0 and drop ref_vld, even if a pop happens in the same cycle: no push-through when full.
REQ-023 SHALL, when empty, not bypass a same-cycle push to a sum: sum_vld is an underflow, no pop happens, out_vld=0, and the push still completes.
REQ-024 SHALL set err_ovf when ref_vld=1 and ref_rdy=0; the FIFO is unchanged.
REQ-025 SHALL set err_unf when sum_vld=1 and the FIFO is empty.
REQ-026 SHALL leave the error flags sticky until reset.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear the FIFO pointers and count; FIFO storage contents need not be cleared.
REQ-028 SHALL, while rst_n=0, asynchronously clear out_vld, out0, out1, err_ovf and err_unf to 0, with ref_rdy=1.
REQ-029 SHALL, on reset asserted mid-operation, discard queued references with no output pulse; the first edge after release behaves as an empty FIFO.

Configuration
REQ-030 SHALL, with macro SUM_SPLIT_ERR_EN defined, implement err_ovf and err_unf per REQ-024 to REQ-026.
REQ-031 SHALL, with SUM_SPLIT_ERR_EN undefined, tie err_ovf and err_unf to constant 0 and build no error flops; all other behaviour is identical.

Verification
REQ-032 SHALL cover basic recovery: push ref 0x10; next cycle sum_vld with sum0=0x15, sum1=0x30 -> one cycle later out_vld=1, out0=0x05, out1=0x20.
REQ-033 SHALL cover wrap-around arithmetic: ref 0xF0, sum0=0x10, sum1=0xEF -> out0=0x20, out1=0xFF.
REQ-034 SHALL cover full FIFO: push 4 refs with no sums -> ref_rdy=0; 5th ref_vld sets err_ovf=1; then 4 sums -> 4 out_vld pulses in push order, and ref_rdy returns to 1 after the first pop.
REQ-035 SHALL cover underflow: sum_vld with empty FIFO and a same-cycle ref push -> out_vld stays 0, err_unf=1, count=1; the next sum consumes that ref.
REQ-036 SHALL cover mid-operation reset: 3 refs queued, rst_n pulsed low -> outputs 0, ref_rdy=1; a sum after release gives err_unf=1 with the macro defined and err_unf=0 with it undefined.
